multdiv_sequencer: RTL and testbench
====================================

Name: multdiv_sequencer

Overview:
- Control FSM that sequences the shared iterative multiply/divide datapath.
- Accepts one-cycle start requests from the execute stage and issues operand-load and per-iteration step enables to the datapath.
- Owns the iteration counter, and reports busy, result-ready and divide-by-zero exception back to the pipeline stall logic.

Parameters:
MULT_STEPS, 32, number of datapath iterations for a multiply
DIV_STEPS, 33, number of datapath iterations for a divide
CNT_W, 6, iteration counter width; must hold max(MULT_STEPS, DIV_STEPS)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start_mult  input  1  one-cycle request: begin multiply
start_div  input  1  one-cycle request: begin divide
divisor_zero  input  1  divisor operand is zero; sampled only with start_div
load  output  1  datapath loads operands this cycle
step  output  1  datapath performs one iteration this cycle
op_is_div  output  1  current or last operation is a divide (datapath mode select)
count  output  CNT_W  iteration index within RUN, 0..N-1; 0 elsewhere
busy  output  1  operation in progress; pipeline must stall
result_ready  output  1  one-cycle pulse: result/exception valid
exception  output  1  divide-by-zero flag, valid with result_ready

Behaviour:
- Reset (reset_n low at a rising edge), regardless of state: state=IDLE, count=0, op_is_div=0. Every output is then 0.
- Reset mid-operation aborts with no result_ready pulse.
- States: IDLE, LOAD, RUN, DONE. Registered state; outputs decode from state, count and op_is_div only.
- Output decode per state:
  - IDLE: all outputs 0 except op_is_div, which holds its last value.
  - LOAD: load=1, busy=1.
  - RUN: step=1, busy=1, count = current index.
  - DONE: result_ready=1, busy=0; exception as latched.
- Start arbitration:
  - Start = start_mult | start_div, sampled at every rising edge in any state.
  - start_div has priority when both are high; op_is_div is latched from it.
  - The exception latch clears on every accepted start.
- Transitions:
  - IDLE --start--> LOAD.
  - start_div with divisor_zero goes instead to DONE with exception=1 (no LOAD/RUN); result_ready appears the cycle after the request.
  - LOAD --> RUN with count=0.
  - RUN: count increments each cycle. On the cycle where count = N-1 (N = DIV_STEPS if op_is_div else MULT_STEPS), next state is DONE.
  - DONE --> IDLE, unless a start is present, in which case it follows the IDLE start rules.
- Restart: a start accepted in LOAD or RUN aborts the current operation. No result_ready is issued for the aborted operation. The FSM re-enters LOAD (or DONE for divide-by-zero) with the new op_is_div, and count resets to 0.
- Latency: request sampled at edge E0.
  - LOAD occupies cycle 1, RUN occupies cycles 2..N+1, DONE/result_ready occurs in cycle N+2.
  - Multiply: ready in cycle 34. Divide: ready in cycle 35.
  - busy is high for exactly N+1 cycles.
- Counter arithmetic: unsigned, CNT_W bits. It never exceeds N-1, with no wrap in legal use. Compare equality only against N-1.
- divisor_zero is ignored when start_div=0 and outside start sampling.
- step and load are never high in the same cycle; result_ready and busy are never high together.

Test Plan:
1. Reset, then start_mult pulse → load high cycle 1; step high cycles 2..33 with count 0..31; result_ready=1, exception=0, op_is_div=0 in cycle 34; busy high for exactly 33 cycles.
2. start_div with divisor_zero=0 → step high for 33 cycles (count 0..32); result_ready in cycle 35; op_is_div=1; exception=0.
3. start_div with divisor_zero=1 → no load or step; result_ready=1, exception=1 in cycle 1; busy stays 0; next idle cycle all outputs 0 except op_is_div=1.
4. start_mult, then start_div at count=10 of RUN → no ready pulse for the multiply; load next cycle; op_is_div=1; 33 fresh steps; single result_ready.
5. start_mult and start_div asserted together → divide sequence (op_is_div=1, 33 steps); start issued in the DONE cycle → LOAD the following cycle, back-to-back with no idle gap.
6. reset_n low during RUN at count=5 → next cycle all outputs 0, no result_ready; a subsequent start_mult completes normally in 34 cycles.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Handshake between the execute stage and the multiply/divide sequencer.
// master = execute/pipeline side, slave = sequencer.
interface multdiv_sequencer_if #(
  parameter int unsigned CNT_W = 6
);
  logic             start_mult;
  logic             start_div;
  logic             divisor_zero;
  logic             load;
  logic             step;
  logic             op_is_div;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             result_ready;
  logic             exception;

  modport master (
    output start_mult,
    output start_div,
    output divisor_zero,
    input  load,
    input  step,
    input  op_is_div,
    input  count,
    input  busy,
    input  result_ready,
    input  exception
  );

  modport slave (
    input  start_mult,
    input  start_div,
    input  divisor_zero,
    output load,
    output step,
    output op_is_div,
    output count,
    output busy,
    output result_ready,
    output exception
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// Control FSM for the shared iterative multiply/divide datapath: issues load and step
// enables, owns the iteration counter, and reports busy / result-ready / divide-by-zero.
module multdiv_sequencer #(
  parameter int unsigned MULT_STEPS = 32,
  parameter int unsigned DIV_STEPS  = 33,
  parameter int unsigned CNT_W      = 6
) (
  input logic                   clock,
  input logic                   reset_n,
  multdiv_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  localparam logic [CNT_W-1:0] MultLast = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DivLast  = CNT_W'(DIV_STEPS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             op_is_div_q, op_is_div_d;
  logic             exc_q, exc_d;

  logic             start;
  logic [CNT_W-1:0] run_last;

  logic             load_o, step_o, busy_o, ready_o, exc_o;
  logic [CNT_W-1:0] count_o;

  assign start    = bus.start_mult | bus.start_div;
  assign run_last = op_is_div_q ? DivLast : MultLast;

  // A start in any state (including LOAD/RUN) aborts the current operation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_is_div_d = op_is_div_q;
    exc_d       = exc_q;
    if (start) begin
      op_is_div_d = bus.start_div;
      count_d     = '0;
      if (bus.start_div && bus.divisor_zero) begin
        state_d = StDone;
        exc_d   = 1'b1;
      end else begin
        state_d = StLoad;
        exc_d   = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StLoad: begin
          state_d = StRun;
          count_d = '0;
        end
        StRun: begin
          if (count_q == run_last) begin
            state_d = StDone;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      op_is_div_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_is_div_q <= op_is_div_d;
      exc_q       <= exc_d;
    end
  end

  always_comb begin
    load_o  = 1'b0;
    step_o  = 1'b0;
    busy_o  = 1'b0;
    ready_o = 1'b0;
    exc_o   = 1'b0;
    count_o = '0;
    unique case (state_q)
      StIdle: load_o = 1'b0;
      StLoad: begin
        load_o = 1'b1;
        busy_o = 1'b1;
      end
      StRun: begin
        step_o  = 1'b1;
        busy_o  = 1'b1;
        count_o = count_q;
      end
      StDone: begin
        ready_o = 1'b1;
        exc_o   = exc_q;
      end
      default: load_o = 1'b0;
    endcase
  end

  assign bus.load         = load_o;
  assign bus.step         = step_o;
  assign bus.op_is_div    = op_is_div_q;
  assign bus.count        = count_o;
  assign bus.busy         = busy_o;
  assign bus.result_ready = ready_o;
  assign bus.exception    = exc_o;

  a_load_step_excl : assert property (@(posedge clock) disable iff (!reset_n)
    !(load_o && step_o));
  a_ready_busy_excl : assert property (@(posedge clock) disable iff (!reset_n)
    !(ready_o && busy_o));

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_multdiv_sequencer;
  localparam int MS = 32;
  localparam int DS = 33;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  // Model: cycles elapsed since the last accepted start (1 = first cycle after the request)
  bit m_active;
  int m_k;
  bit m_div;
  bit m_zero;
  bit m_last_div;

  multdiv_sequencer_if #(.CNT_W(6)) bus ();

  multdiv_sequencer #(
    .MULT_STEPS(MS),
    .DIV_STEPS (DS),
    .CNT_W     (6)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Vector layout: {load, step, op_is_div, count[5:0], busy, result_ready, exception}
  function automatic logic [11:0] obs_vec();
    return {bus.load, bus.step, bus.op_is_div, bus.count, bus.busy, bus.result_ready,
            bus.exception};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic       ld, st, bz, rd, ex;
    logic [5:0] cn;
    int         n;
    ld = 0; st = 0; bz = 0; rd = 0; ex = 0; cn = '0;
    if (m_active) begin
      n = m_div ? DS : MS;
      if (m_zero) begin
        if (m_k == 1) begin rd = 1; ex = 1; end
      end else if (m_k == 1) begin
        ld = 1; bz = 1;
      end else if (m_k <= n + 1) begin
        st = 1; bz = 1; cn = 6'(m_k - 2);
      end else if (m_k == n + 2) begin
        rd = 1;
      end
    end
    return {ld, st, m_last_div, cn, bz, rd, ex};
  endfunction

  task automatic tick(input logic sm, input logic sd, input logic dz, input logic rn);
    @(negedge clock);
    bus.start_mult   = sm;
    bus.start_div    = sd;
    bus.divisor_zero = dz;
    reset_n          = rn;
    @(posedge clock);
    if (!rn) begin
      m_active   = 0;
      m_last_div = 0;
    end else if (sm || sd) begin
      m_active   = 1;
      m_k        = 1;
      m_div      = sd;
      m_zero     = sd && dz;
      m_last_div = sd;
    end else if (m_active) begin
      m_k++;
      if (m_k > (m_zero ? 1 : (m_div ? DS + 2 : MS + 2))) m_active = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1, 0);
      checks++;
      if (obs_vec() !== 12'h000) begin
        $display("FAIL reset cyc%0d got=%h exp=000", i, obs_vec());
        errors++;
      end
    end
    tick(0, 0, 0, 1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL reset_release got=%h exp=%h", obs_vec(), exp_vec());
      errors++;
    end
  endtask

  task automatic test_mult();
    int busy_n = 0, rdy_n = 0, rdy_at = -1;
    tick(1, 0, 0, 1);
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick(0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL mult cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        errors++;
      end
      busy_n += int'(bus.busy);
      if (bus.result_ready) begin rdy_n++; rdy_at = c; end
    end
    checks++;
    if (busy_n != 33 || rdy_n != 1 || rdy_at != 34) begin
      $display("FAIL mult_timing busy=%0d ready=%0d at=%0d exp busy=33 ready=1 at=34",
               busy_n, rdy_n, rdy_at);
      errors++;
    end
  endtask

  task automatic test_div();
    int step_n = 0, rdy_at = -1;
    tick(0, 1, 0, 1);
    for (int c = 1; c <= 37; c++) begin
      if (c > 1) tick(0, 0, c[0], 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL div cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        errors++;
      end
      step_n += int'(bus.step);
      if (bus.result_ready) rdy_at = c;
    end
    checks++;
    if (step_n != 33 || rdy_at != 35 || bus.op_is_div !== 1'b1) begin
      $display("FAIL div_timing steps=%0d at=%0d div=%b exp steps=33 at=35 div=1",
               step_n, rdy_at, bus.op_is_div);
      errors++;
    end
  endtask

  task automatic test_div_zero();
    tick(0, 1, 1, 1);
    checks++;
    if (obs_vec() !== 12'h203) begin
      $display("FAIL divzero_done got=%h exp=203", obs_vec());
      errors++;
    end
    for (int c = 2; c <= 4; c++) begin
      tick(0, 0, 1, 1);
      checks++;
      if (obs_vec() !== 12'h200 || obs_vec() !== exp_vec()) begin
        $display("FAIL divzero_idle cyc%0d got=%h exp=200", c, obs_vec());
        errors++;
      end
    end
  endtask

  task automatic test_restart();
    int step_n = 0, rdy_n = 0;
    tick(1, 0, 0, 1);
    for (int c = 2; c <= 12; c++) begin
      tick(0, 0, 0, 1);
      rdy_n += int'(bus.result_ready);
    end
    checks++;
    if (bus.step !== 1'b1 || bus.count !== 6'd10) begin
      $display("FAIL restart_pre step=%b count=%0d exp step=1 count=10", bus.step, bus.count);
      errors++;
    end
    tick(0, 1, 0, 1);
    checks++;
    if (obs_vec() !== 12'hA04 || obs_vec() !== exp_vec()) begin
      $display("FAIL restart_load got=%h exp=a04", obs_vec());
      errors++;
    end
    for (int c = 2; c <= 40; c++) begin
      tick(0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL restart cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        errors++;
      end
      step_n += int'(bus.step);
      rdy_n  += int'(bus.result_ready);
    end
    checks++;
    if (step_n != 33 || rdy_n != 1) begin
      $display("FAIL restart_count steps=%0d ready=%0d exp steps=33 ready=1", step_n, rdy_n);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    int rdy_at = -1;
    tick(1, 1, 0, 1);
    checks++;
    if (bus.load !== 1'b1 || bus.op_is_div !== 1'b1) begin
      $display("FAIL both_start load=%b div=%b exp load=1 div=1", bus.load, bus.op_is_div);
      errors++;
    end
    for (int c = 2; c <= 35; c++) tick(0, 0, 0, 1);
    checks++;
    if (obs_vec() !== 12'h202 || obs_vec() !== exp_vec()) begin
      $display("FAIL b2b_done got=%h exp=202", obs_vec());
      errors++;
    end
    tick(1, 0, 0, 1);
    checks++;
    if (obs_vec() !== 12'h804) begin
      $display("FAIL b2b_load got=%h exp=804", obs_vec());
      errors++;
    end
    for (int c = 2; c <= 35; c++) begin
      tick(0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL b2b cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        errors++;
      end
      if (bus.result_ready) rdy_at = c;
    end
    checks++;
    if (rdy_at != 34) begin
      $display("FAIL b2b_ready at=%0d exp=34", rdy_at);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    int rdy_n = 0, rdy_at = -1;
    tick(1, 0, 0, 1);
    for (int c = 2; c <= 7; c++) tick(0, 0, 0, 1);
    checks++;
    if (bus.count !== 6'd5 || bus.step !== 1'b1) begin
      $display("FAIL rstmid_pre count=%0d step=%b exp count=5 step=1", bus.count, bus.step);
      errors++;
    end
    tick(0, 0, 0, 0);
    checks++;
    if (obs_vec() !== 12'h000) begin
      $display("FAIL rstmid_abort got=%h exp=000", obs_vec());
      errors++;
    end
    for (int c = 0; c < 40; c++) begin
      tick(0, 0, 0, 1);
      rdy_n += int'(bus.result_ready);
    end
    checks++;
    if (rdy_n != 0) begin
      $display("FAIL rstmid_noready ready=%0d exp=0", rdy_n);
      errors++;
    end
    tick(1, 0, 0, 1);
    for (int c = 2; c <= 36; c++) begin
      tick(0, 0, 0, 1);
      if (bus.result_ready) rdy_at = c;
    end
    checks++;
    if (rdy_at != 34) begin
      $display("FAIL rstmid_rerun ready_at=%0d exp=34", rdy_at);
      errors++;
    end
  endtask

  task automatic test_random();
    logic sm, sd, dz, rn;
    for (int c = 0; c < 3000; c++) begin
      sm = ($urandom_range(0, 49) == 0);
      sd = ($urandom_range(0, 49) == 0);
      dz = ($urandom_range(0, 2) == 0);
      rn = ($urandom_range(0, 299) != 0);
      tick(sm, sd, dz, rn);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL random cyc%0d got=%h exp=%h", c, obs_vec(), exp_vec());
        errors++;
      end
    end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    m_active         = 0;
    m_k              = 0;
    m_div            = 0;
    m_zero           = 0;
    m_last_div       = 0;
    reset_n          = 1'b0;
    bus.start_mult   = 1'b0;
    bus.start_div    = 1'b0;
    bus.divisor_zero = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
